// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings and
// default reset/bubble constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StDrop  = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NopInstr = 16'h0000;  // ADD R0,R0,R0
  localparam logic [15:0] ResetPc  = 16'h0000;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID, buffers one
// instruction across stalls and squashes wrong-path fetches on EX redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = ResetPc,
  parameter logic [15:0] NOP_INSTR = NopInstr
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          ex_redirect,
  input  logic [15:0]   ex_target,
  fetch_stage_if.master imem,
  output logic [15:0]   if_pc,
  output logic          id_valid,
  output logic [15:0]   id_instr,
  output logic [15:0]   id_pc
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  hold_q, hold_d;
  logic [15:0]  tgt_q, tgt_d;
  logic         id_valid_q, id_valid_d;
  logic [15:0]  id_instr_q, id_instr_d;
  logic [15:0]  id_pc_q, id_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    tgt_d      = tgt_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    // Redirect squashes IF/ID even under stall; otherwise an unstalled ID has
    // consumed its entry, so default to a bubble unless a load happens below.
    if (ex_redirect || !stall) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end

    unique case (state_q)
      StFetch: begin
        if (imem.ready) begin
          if (ex_redirect) begin
            pc_d = ex_target;
          end else if (stall) begin
            hold_d  = imem.rdata;
            state_d = StHold;
          end else begin
            id_valid_d = 1'b1;
            id_instr_d = imem.rdata;
            id_pc_d    = pc_q;
            pc_d       = pc_inc(pc_q);
          end
        end else if (ex_redirect) begin
          // Outstanding request pins imem_addr; park the target until ready.
          tgt_d   = ex_target;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (ex_redirect) begin
          tgt_d = ex_target;
        end
        if (imem.ready) begin
          pc_d    = ex_redirect ? ex_target : tgt_q;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (ex_redirect) begin
          pc_d    = ex_target;
          state_d = StFetch;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = hold_q;
          id_pc_d    = pc_q;
          pc_d       = pc_inc(pc_q);
          state_d    = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      hold_q     <= '0;
      tgt_q      <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      tgt_q      <= tgt_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign imem.req  = rst_n && (state_q != StHold);
  assign imem.addr = pc_q;
  assign if_pc     = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural imem and an IF/ID scoreboard.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_redirect;
  logic [15:0] ex_target;
  logic [15:0] if_pc;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .imem       (bus),
    .if_pc      (if_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'hB0DE) return 16'h1234;
    return a ^ 16'h5A5A;
  endfunction

  // Memory: zero-wait combinational mode, or fixed latency of lat cycles.
  logic        zw;
  logic        mem_en;
  int unsigned lat;
  logic        rdy_q;
  logic [15:0] rdata_q;
  int unsigned cnt_q;

  assign bus.ready = mem_en && (zw ? bus.req : rdy_q);
  assign bus.rdata = zw ? memf(bus.addr) : rdata_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= 0;
    end else begin
      rdy_q <= 1'b0;
      if (zw || !mem_en) begin
        cnt_q <= 0;
      end else if (bus.req && !rdy_q) begin
        if (cnt_q == lat - 1) begin
          rdy_q   <= 1'b1;
          rdata_q <= memf(bus.addr);
          cnt_q   <= 0;
        end else begin
          cnt_q <= cnt_q + 1;
        end
      end
    end
  end

  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic pv;
  logic [15:0] ppc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = memf(pc);
    sb_q.push_back(e);
  endtask

  // Advance one cycle; any new IF/ID entry is popped from the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (id_valid && (!pv || id_pc != ppc)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pc", id_pc, 16'hxxxx);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
      end
    end
    pv  = id_valid;
    ppc = id_pc;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pv = 1'b0;
    ppc = '0;
    rst_n = 1'b0;
    stall = 1'b0;
    ex_redirect = 1'b0;
    ex_target = '0;
    zw = 1'b1;
    mem_en = 1'b1;
    lat = 3;

    // Reset state.
    #1;
    chk("rst_req", 16'(bus.req), 16'h0);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_valid", 16'(id_valid), 16'h0);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_id_pc", id_pc, 16'h0000);

    // Zero-wait streaming: one instruction per cycle.
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0000); push(16'h0001); push(16'h0002);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stream_valid", 16'(id_valid), 16'h1);
    end
    chk("stream_if_pc", if_pc, 16'h0003);

    // Redirect with ready to FFFF, then wrap.
    ex_redirect = 1'b1; ex_target = 16'hFFFF;
    tick();
    chk("redir_valid", 16'(id_valid), 16'h0);
    chk("redir_pc", if_pc, 16'hFFFF);
    ex_redirect = 1'b0;
    push(16'hFFFF);
    tick();
    mem_en = 1'b0;
    chk("wrap_addr", bus.addr, 16'h0000);
    tick();
    chk("wrap_bubble", 16'(id_valid), 16'h0);

    // Stall for 3 cycles as the fetch at B0DE returns.
    mem_en = 1'b1;
    ex_redirect = 1'b1; ex_target = 16'hB0DD;
    tick();
    ex_redirect = 1'b0;
    push(16'hB0DD);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", 16'(bus.req), 16'h0);
      chk("hold_id_pc", id_pc, 16'hB0DD);
      chk("hold_valid", 16'(id_valid), 16'h1);
    end
    mem_en = 1'b0;
    stall = 1'b0;
    push(16'hB0DE);
    tick();
    chk("hold_instr", id_instr, 16'h1234);
    chk("hold_next_addr", bus.addr, 16'hB0DF);

    // Redirect while a 3-cycle request to 1055 is pending.
    mem_en = 1'b1;
    ex_redirect = 1'b1; ex_target = 16'h1055;
    tick();
    ex_redirect = 1'b0;
    zw = 1'b0;
    tick();
    ex_redirect = 1'b1; ex_target = 16'h1057;
    tick();
    ex_redirect = 1'b0;
    chk("drop_addr0", bus.addr, 16'h1055);
    chk("drop_req", 16'(bus.req), 16'h1);
    tick();
    chk("drop_addr1", bus.addr, 16'h1055);
    tick();
    chk("drop_valid", 16'(id_valid), 16'h0);
    chk("drop_next_addr", bus.addr, 16'h1057);
    push(16'h1057);
    for (int i = 0; i < 4; i++) tick();
    mem_en = 1'b0;

    // Stall and redirect together: redirect wins.
    zw = 1'b1; mem_en = 1'b1;
    stall = 1'b1; ex_redirect = 1'b1; ex_target = 16'hC000;
    tick();
    mem_en = 1'b0;
    chk("sr_valid", 16'(id_valid), 16'h0);
    chk("sr_instr", id_instr, 16'h0000);
    chk("sr_pc", if_pc, 16'hC000);
    stall = 1'b0; ex_redirect = 1'b0;

    // Reset pulse in DROP.
    zw = 1'b0; mem_en = 1'b1;
    tick();
    ex_redirect = 1'b1; ex_target = 16'h2222;
    tick();
    ex_redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 16'(bus.req), 16'h0);
    chk("arst_if_pc", if_pc, 16'h0000);
    chk("arst_valid", 16'(id_valid), 16'h0);
    chk("arst_id_pc", id_pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b0;
    tick();
    chk("arst_addr", bus.addr, 16'h0000);
    chk("arst_req_on", 16'(bus.req), 16'h1);
    zw = 1'b1; mem_en = 1'b1;
    push(16'h0000);
    tick();
    mem_en = 1'b0;
    tick();
    chk("arst_after_addr", bus.addr, 16'h0001);
    chk("sb_empty", 16'(sb_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
